imem_boot_controller: RTL and testbench

Sequences the instruction memory of the single-cycle core.
- After reset, streams a program into the memory write port through a valid/ready loader interface, then releases the core.
- While the core runs, translates the core PC to a word read address and returns the fetched instruction.
- Substitutes a NOP for out-of-range fetches and on every fetch outside RUN.
- Sits between the core fetch path, the instruction memory array and the external loader (UART/JTAG bridge).

---
 rtl/imem_boot_controller_if.sv | 36 +++
 rtl/imem_boot_controller.sv | 105 ++++++++++
 tb/tb_imem_boot_controller.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_boot_controller_if.sv
// Loader, core fetch and instruction-memory signals of the boot controller.
interface imem_boot_controller_if #(
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  load_valid;
  logic                  load_ready;
  logic [31:0]           load_data;
  logic                  load_last;
  logic                  run_req;
  logic                  reload;
  logic [31:0]           pc;
  logic [31:0]           instruction;
  logic                  cpu_run;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [31:0]           mem_wdata;
  logic [ADDR_WIDTH-1:0] mem_raddr;
  logic [31:0]           mem_rdata;
  logic [ADDR_WIDTH:0]   word_count;
  logic                  pc_fault;
  logic                  load_error;

  // Controller side.
  modport slave (
    input  load_valid, load_data, load_last, run_req, reload, pc, mem_rdata,
    output load_ready, instruction, cpu_run, mem_we, mem_waddr, mem_wdata,
           mem_raddr, word_count, pc_fault, load_error
  );

  // Environment side: loader, core and memory array.
  modport master (
    output load_valid, load_data, load_last, run_req, reload, pc, mem_rdata,
    input  load_ready, instruction, cpu_run, mem_we, mem_waddr, mem_wdata,
           mem_raddr, word_count, pc_fault, load_error
  );
endinterface

// File: rtl/imem_boot_controller.sv
// Instruction memory boot sequencer: streams a program into memory, then
// releases the core and serves its fetches, substituting NOPs when invalid.
module imem_boot_controller #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter logic [31:0] NOP_INSN   = 32'h0000_0013
) (
  input  logic                   clk,
  input  logic                   rst_n,
  imem_boot_controller_if.slave  bus
);
  localparam int unsigned      CNT_W    = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'((1 << ADDR_WIDTH) - 1);

  typedef enum logic [2:0] {IDLE, LOAD, DONE, RUN, ERROR} state_t;

  state_t           state;
  logic [CNT_W-1:0] word_count;
  logic             cpu_run;
  logic             pc_fault;
  logic             load_error;

  logic             load_ready_c;
  logic             accept_c;
  logic             pc_in_range_c;
  logic             unused_pc_lsbs;

  // Handshake and range decode.
  assign load_ready_c   = (state == IDLE) || (state == LOAD);
  assign accept_c       = bus.load_valid && load_ready_c;
  assign pc_in_range_c  = (bus.pc[31:ADDR_WIDTH+2] == '0);
  assign unused_pc_lsbs = ^bus.pc[1:0];

  // Memory write port follows the accepted word directly.
  assign bus.load_ready  = load_ready_c;
  assign bus.mem_we      = accept_c;
  assign bus.mem_waddr   = word_count[ADDR_WIDTH-1:0];
  assign bus.mem_wdata   = bus.load_data;

  // Fetch path: word address from PC, NOP unless running and in range.
  assign bus.mem_raddr   = bus.pc[ADDR_WIDTH+1:2];
  assign bus.instruction = ((state == RUN) && pc_in_range_c) ? bus.mem_rdata : NOP_INSN;

  assign bus.cpu_run     = cpu_run;
  assign bus.word_count  = word_count;
  assign bus.pc_fault    = pc_fault;
  assign bus.load_error  = load_error;

  // Sequencer state, load counter and sticky flags; cpu_run tracks entry into RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      word_count <= '0;
      cpu_run    <= 1'b0;
      pc_fault   <= 1'b0;
      load_error <= 1'b0;
    end else begin
      if (accept_c) begin
        word_count <= word_count + CNT_W'(1);
      end
      if ((state == RUN) && !pc_in_range_c) begin
        pc_fault <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (accept_c) begin
            state <= bus.load_last ? DONE : LOAD;
          end else if (bus.run_req) begin
            state   <= RUN;
            cpu_run <= 1'b1;
          end
        end
        LOAD: begin
          if (accept_c) begin
            if (bus.load_last) begin
              state <= DONE;
            end else if (word_count == LAST_IDX) begin
              state      <= ERROR;
              load_error <= 1'b1;
            end
          end
        end
        DONE: begin
          state   <= RUN;
          cpu_run <= 1'b1;
        end
        RUN: begin
          // Reload takes priority over a fault raised in the same cycle.
          if (bus.reload) begin
            state      <= IDLE;
            cpu_run    <= 1'b0;
            word_count <= '0;
            pc_fault   <= 1'b0;
          end
        end
        ERROR: begin
          state <= ERROR;
        end
        default: begin
          state   <= IDLE;
          cpu_run <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_imem_boot_controller.sv
// Bench for imem_boot_controller: writes go through a scoreboard queue checked
// by a monitor; fetch and status values are checked against hand-computed constants.
module tb_imem_boot_controller;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n_a;
  logic rst_n_b;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  imem_boot_controller_if #(.ADDR_WIDTH(8)) bus_a ();
  imem_boot_controller_if #(.ADDR_WIDTH(2)) bus_b ();

  imem_boot_controller #(.ADDR_WIDTH(8), .NOP_INSN(NOP)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .bus(bus_a)
  );
  imem_boot_controller #(.ADDR_WIDTH(2), .NOP_INSN(NOP)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .bus(bus_b)
  );

  // Memory models attached to the write and read ports.
  logic [31:0] mem_a [256];
  logic [31:0] mem_b [4];
  always @(posedge clk) if (bus_a.mem_we) mem_a[bus_a.mem_waddr] <= bus_a.mem_wdata;
  always @(posedge clk) if (bus_b.mem_we) mem_b[bus_b.mem_waddr] <= bus_b.mem_wdata;
  assign bus_a.mem_rdata = mem_a[bus_a.mem_raddr];
  assign bus_b.mem_rdata = mem_b[bus_b.mem_raddr];

  // Expected writes: {addr, data}.
  logic [39:0] q_a [$];
  logic [33:0] q_b [$];
  int exp_addr_a;
  int exp_addr_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write monitors: every mem_we pulse must match the next queued write.
  always @(negedge clk) begin
    if (bus_a.mem_we === 1'b1) begin
      if (q_a.size() == 0) begin
        chk("a_unexpected_write", 32'(bus_a.mem_waddr), 32'hffff_ffff);
      end else begin
        logic [39:0] e;
        e = q_a.pop_front();
        chk("a_waddr", 32'(bus_a.mem_waddr), 32'(e[39:32]));
        chk("a_wdata", bus_a.mem_wdata, e[31:0]);
      end
    end
  end

  always @(negedge clk) begin
    if (bus_b.mem_we === 1'b1) begin
      if (q_b.size() == 0) begin
        chk("b_unexpected_write", 32'(bus_b.mem_waddr), 32'hffff_ffff);
      end else begin
        logic [33:0] e;
        e = q_b.pop_front();
        chk("b_waddr", 32'(bus_b.mem_waddr), 32'(e[33:32]));
        chk("b_wdata", bus_b.mem_wdata, e[31:0]);
      end
    end
  end

  task automatic send_a(input logic [31:0] d, input logic last);
    q_a.push_back({8'(exp_addr_a), d});
    exp_addr_a++;
    bus_a.load_valid = 1'b1;
    bus_a.load_data  = d;
    bus_a.load_last  = last;
    tick();
    bus_a.load_valid = 1'b0;
    bus_a.load_last  = 1'b0;
  endtask

  task automatic send_b(input logic [31:0] d);
    q_b.push_back({2'(exp_addr_b), d});
    exp_addr_b++;
    bus_b.load_valid = 1'b1;
    bus_b.load_data  = d;
    bus_b.load_last  = 1'b0;
    tick();
    bus_b.load_valid = 1'b0;
  endtask

  task automatic fetch_a(input string name, input logic [31:0] pc, input logic [31:0] exp);
    bus_a.pc = pc;
    #1;
    chk(name, bus_a.instruction, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    {bus_a.load_valid, bus_a.load_last, bus_a.run_req, bus_a.reload} = '0;
    {bus_b.load_valid, bus_b.load_last, bus_b.run_req, bus_b.reload} = '0;
    bus_a.load_data = '0;  bus_b.load_data = '0;
    bus_a.pc = '0;         bus_b.pc = '0;
    tick();
    tick();

    // Values held during reset.
    chk("rst_load_ready", 32'(bus_a.load_ready), 32'd1);
    chk("rst_mem_we",     32'(bus_a.mem_we),     32'd0);
    chk("rst_insn",       bus_a.instruction,     NOP);
    chk("rst_cpu_run",    32'(bus_a.cpu_run),    32'd0);
    chk("rst_word_count", 32'(bus_a.word_count), 32'd0);
    chk("rst_pc_fault",   32'(bus_a.pc_fault),   32'd0);
    chk("rst_load_error", 32'(bus_a.load_error), 32'd0);
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;
    tick();

    // 3-word load, back to back.
    exp_addr_a = 0;
    send_a(32'h0050_0093, 1'b0);
    send_a(32'h00a0_0113, 1'b0);
    send_a(32'h0020_81b3, 1'b1);
    chk("done_load_ready", 32'(bus_a.load_ready), 32'd0);
    chk("done_cpu_run",    32'(bus_a.cpu_run),    32'd0);
    chk("done_word_count", 32'(bus_a.word_count), 32'd3);
    tick();
    chk("run_cpu_run",     32'(bus_a.cpu_run),    32'd1);
    chk("run_load_ready",  32'(bus_a.load_ready), 32'd0);

    // Fetches from the loaded program.
    fetch_a("fetch_pc0", 32'h0, 32'h0050_0093);
    fetch_a("fetch_pc7", 32'h7, 32'h00a0_0113);
    chk("raddr_pc7", 32'(bus_a.mem_raddr), 32'd1);
    fetch_a("fetch_pcb", 32'hb, 32'h0020_81b3);

    // Loader offers in RUN are ignored.
    bus_a.load_valid = 1'b1;
    #1;
    chk("run_ignores_load_we", 32'(bus_a.mem_we), 32'd0);
    bus_a.load_valid = 1'b0;

    // Out-of-range fetch.
    fetch_a("fetch_oor", 32'h0000_0400, NOP);
    chk("oor_fault_before", 32'(bus_a.pc_fault), 32'd0);
    tick();
    chk("oor_fault_set", 32'(bus_a.pc_fault), 32'd1);
    fetch_a("fetch_after_oor", 32'h0, 32'h0050_0093);
    tick();
    chk("oor_fault_sticky", 32'(bus_a.pc_fault), 32'd1);
    chk("oor_still_run",    32'(bus_a.cpu_run),  32'd1);

    // Reload back to IDLE.
    bus_a.reload = 1'b1;
    tick();
    bus_a.reload = 1'b0;
    chk("reload_cpu_run",    32'(bus_a.cpu_run),    32'd0);
    chk("reload_pc_fault",   32'(bus_a.pc_fault),   32'd0);
    chk("reload_word_count", 32'(bus_a.word_count), 32'd0);
    chk("reload_load_ready", 32'(bus_a.load_ready), 32'd1);
    fetch_a("idle_fetch_nop", 32'h0, NOP);

    // Backpressure gaps 1,0,0,1; run_req alongside the first word loses to the load.
    exp_addr_a = 0;
    bus_a.run_req = 1'b1;
    send_a(32'hdead_0001, 1'b0);
    bus_a.run_req = 1'b0;
    chk("bp_load_wins_cpu_run", 32'(bus_a.cpu_run),    32'd0);
    chk("bp_wc1",               32'(bus_a.word_count), 32'd1);
    tick();
    tick();
    chk("bp_gap_wc", 32'(bus_a.word_count), 32'd1);
    send_a(32'hbeef_0002, 1'b1);
    chk("bp_wc2", 32'(bus_a.word_count), 32'd2);
    tick();
    chk("bp_cpu_run", 32'(bus_a.cpu_run), 32'd1);
    fetch_a("bp_fetch1", 32'h4, 32'hbeef_0002);
    fetch_a("bp_fetch0", 32'h0, 32'hdead_0001);
    bus_a.reload = 1'b1;
    tick();
    bus_a.reload = 1'b0;

    // Reset after 2 of 5 words, then start from preloaded memory.
    exp_addr_a = 0;
    send_a(32'h1234_5678, 1'b0);
    send_a(32'h9abc_def0, 1'b0);
    chk("mid_wc2", 32'(bus_a.word_count), 32'd2);
    rst_n_a = 1'b0;
    #1;
    chk("mid_rst_load_ready", 32'(bus_a.load_ready), 32'd1);
    chk("mid_rst_word_count", 32'(bus_a.word_count), 32'd0);
    chk("mid_rst_insn",       bus_a.instruction,     NOP);
    tick();
    rst_n_a = 1'b1;
    tick();
    bus_a.run_req = 1'b1;
    tick();
    bus_a.run_req = 1'b0;
    chk("preload_cpu_run", 32'(bus_a.cpu_run), 32'd1);
    fetch_a("preload_fetch0", 32'h0, 32'h1234_5678);
    fetch_a("preload_fetch1", 32'h4, 32'h9abc_def0);

    // Overflow on the 4-word memory.
    exp_addr_b = 0;
    send_b(32'h0000_00a0);
    send_b(32'h0000_00a1);
    send_b(32'h0000_00a2);
    chk("ovf_no_error_yet", 32'(bus_b.load_error), 32'd0);
    send_b(32'h0000_00a3);
    chk("ovf_load_error", 32'(bus_b.load_error), 32'd1);
    chk("ovf_load_ready", 32'(bus_b.load_ready), 32'd0);
    chk("ovf_word_count", 32'(bus_b.word_count), 32'd4);
    bus_b.run_req = 1'b1;
    tick();
    bus_b.run_req = 1'b0;
    bus_b.reload  = 1'b1;
    tick();
    bus_b.reload  = 1'b0;
    bus_b.load_valid = 1'b1;
    #1;
    chk("ovf_no_write", 32'(bus_b.mem_we), 32'd0);
    tick();
    bus_b.load_valid = 1'b0;
    chk("ovf_cpu_run",     32'(bus_b.cpu_run),    32'd0);
    chk("ovf_error_hold",  32'(bus_b.load_error), 32'd1);
    chk("ovf_ready_hold",  32'(bus_b.load_ready), 32'd0);
    rst_n_b = 1'b0;
    #1;
    chk("ovf_rst_error", 32'(bus_b.load_error), 32'd0);
    chk("ovf_rst_ready", 32'(bus_b.load_ready), 32'd1);
    chk("ovf_rst_wc",    32'(bus_b.word_count), 32'd0);
    tick();
    rst_n_b = 1'b1;
    tick();

    chk("a_writes_drained", 32'(q_a.size()), 32'd0);
    chk("b_writes_drained", 32'(q_b.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
